// File: rtl/eeprom_bist.sv
// eeprom_bist: built-in self test for an I2C EEPROM behind a byte-wide
// read/write controller. A run writes a pattern into BYTE_N consecutive
// addresses starting at START_ADDR, then reads every byte back and compares.
// Mismatches and missing completions are counted, and the first failing
// address is kept.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle request to run a test (accepted in IDLE only)
//   pattern_sel, seed     pattern choice and seed, latched when start is accepted
//   i2c_rh_wl             1 = read, 0 = write
//   i2c_exec              one-cycle operation trigger
//   i2c_addr              word address of the current operation
//   i2c_data_w            write data
//   i2c_data_r            read data returned by the controller
//   i2c_done              one-cycle completion from the controller
//   busy                  test in progress
//   done                  one-cycle end-of-test pulse
//   pass                  last test finished with zero errors
//   err_cnt               saturating mismatch + timeout count
//   fail_addr             address of the first error
module eeprom_bist #(
  parameter int ADDR_W     = 16,
  parameter int START_ADDR = 0,
  parameter int BYTE_N     = 256,
  parameter int GAP        = 100,
  parameter int WR_WAIT    = 5000,
  parameter int TIMEOUT    = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pattern_sel,
  input  logic [7:0]        seed,
  output logic              i2c_rh_wl,
  output logic              i2c_exec,
  output logic [ADDR_W-1:0] i2c_addr,
  output logic [7:0]        i2c_data_w,
  input  logic [7:0]        i2c_data_r,
  input  logic              i2c_done,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr
);

  typedef enum logic [3:0] {
    IDLE, W_GAP, W_EXEC, W_DONE, W_TWR, R_GAP, R_EXEC, R_DONE, FINISH
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(BYTE_N - 1);
  // Terminal counts; a zero-length wait still costs one cycle in its state.
  localparam logic [31:0] GAP_LAST = (GAP > 0)     ? GAP - 1     : 0;
  localparam logic [31:0] TWR_LAST = (WR_WAIT > 0) ? WR_WAIT - 1 : 0;
  localparam logic [31:0] TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  function automatic logic [7:0] exp_byte(input logic [1:0] sel,
                                          input logic [7:0] sd,
                                          input logic [7:0] a);
    case (sel)
      2'd0:    return a;
      2'd1:    return ~a;
      2'd2:    return a ^ sd;
      default: return sd;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic [31:0]         r_cnt;
  logic [ADDR_W-1:0]   r_index;
  logic [1:0]          r_pat;
  logic [7:0]          r_seed;
  logic [7:0]          r_data_w;
  logic [15:0]         r_err_cnt;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic                r_pass;

  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_exp;
  logic                w_last;
  logic                w_err;
  logic                w_idx_inc;
  logic                w_idx_clr;
  logic                w_accept;

  // Address wraps naturally at the top of the ADDR_W space.
  assign w_addr   = BASE_ADDR + r_index;
  assign w_exp    = exp_byte(r_pat, r_seed, w_addr[7:0]);
  assign w_last   = (r_index == LAST_IDX);
  assign w_accept = (r_state == IDLE) && start;

  assign i2c_addr   = w_addr;
  assign i2c_data_w = r_data_w;
  assign err_cnt    = r_err_cnt;
  assign fail_addr  = r_fail_addr;
  assign pass       = r_pass;

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_idx_inc   = 1'b0;
    w_idx_clr   = 1'b0;
    i2c_exec    = 1'b0;
    i2c_rh_wl   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = W_GAP;
      end
      W_GAP: begin
        if (r_cnt >= GAP_LAST) w_state_nxt = W_EXEC;
      end
      W_EXEC: begin
        i2c_exec    = 1'b1;
        w_state_nxt = W_DONE;
      end
      W_DONE: begin
        // A missing completion is charged as an error, then the write
        // sequence carries on as though it had completed.
        if (i2c_done) begin
          w_state_nxt = W_TWR;
        end else if (r_cnt >= TO_LAST) begin
          w_err       = 1'b1;
          w_state_nxt = W_TWR;
        end
      end
      W_TWR: begin
        if (r_cnt >= TWR_LAST) begin
          if (w_last) begin
            w_idx_clr   = 1'b1;
            w_state_nxt = R_GAP;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = W_GAP;
          end
        end
      end
      R_GAP: begin
        i2c_rh_wl = 1'b1;
        if (r_cnt >= GAP_LAST) w_state_nxt = R_EXEC;
      end
      R_EXEC: begin
        i2c_rh_wl   = 1'b1;
        i2c_exec    = 1'b1;
        w_state_nxt = R_DONE;
      end
      R_DONE: begin
        i2c_rh_wl = 1'b1;
        if (i2c_done || (r_cnt >= TO_LAST)) begin
          // On timeout there is no data to compare; the timeout itself is the error.
          w_err = i2c_done ? (i2c_data_r != w_exp) : 1'b1;
          if (w_last) begin
            w_state_nxt = FINISH;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = R_GAP;
          end
        end
      end
      FINISH: begin
        i2c_rh_wl   = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_index     <= '0;
      r_pat       <= '0;
      r_seed      <= '0;
      r_data_w    <= '0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Every wait counter restarts on entry to its state.
      if ((w_state_nxt != r_state) || (r_state == IDLE)) r_cnt <= '0;
      else                                               r_cnt <= r_cnt + 32'd1;

      if (w_accept) begin
        r_pat       <= pattern_sel;
        r_seed      <= seed;
        r_index     <= '0;
        r_err_cnt   <= '0;
        r_fail_addr <= '0;
        r_pass      <= 1'b0;
      end else begin
        if (w_idx_clr)      r_index <= '0;
        else if (w_idx_inc) r_index <= r_index + 1'b1;
        if (w_err) begin
          r_err_cnt <= sat_inc16(r_err_cnt);
          if (r_err_cnt == 16'd0) r_fail_addr <= w_addr;
        end
        if (r_state == FINISH) r_pass <= (r_err_cnt == 16'd0);
      end

      // Loaded while waiting to write so it is stable for the whole write.
      if (r_state == W_GAP) r_data_w <= w_exp;
    end
  end

endmodule

// File: tb/tb_eeprom_bist.sv
module tb_eeprom_bist;

  localparam int GAP_A = 3;
  localparam int WRW_A = 8;
  localparam int TO_A  = 200;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic a_start, b_start;
  logic [1:0] pattern_sel;
  logic [7:0] seed;

  logic        a_rh_wl, a_exec, a_busy, a_done, a_pass;
  logic [15:0] a_addr, a_err, a_fail;
  logic [7:0]  a_data_w;
  logic [7:0]  a_rdata = 8'h00;
  logic        a_done_in = 1'b0;

  logic        b_rh_wl, b_exec, b_busy, b_done, b_pass;
  logic [15:0] b_addr, b_err, b_fail;
  logic [7:0]  b_data_w;
  logic [7:0]  b_rdata = 8'h00;
  logic        b_done_in = 1'b0;

  int checks = 0;
  int failures = 0;

  logic mon_clr, drop_mode, corrupt_mode;
  logic [1:0] cur_pat;
  logic [7:0] cur_seed;

  always #5 clk = ~clk;

  eeprom_bist #(.ADDR_W(16), .START_ADDR(0), .BYTE_N(256), .GAP(GAP_A),
                .WR_WAIT(WRW_A), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .pattern_sel(pattern_sel), .seed(seed),
    .i2c_rh_wl(a_rh_wl), .i2c_exec(a_exec), .i2c_addr(a_addr), .i2c_data_w(a_data_w),
    .i2c_data_r(a_rdata), .i2c_done(a_done_in), .busy(a_busy), .done(a_done),
    .pass(a_pass), .err_cnt(a_err), .fail_addr(a_fail));

  eeprom_bist #(.ADDR_W(16), .START_ADDR(65534), .BYTE_N(4), .GAP(2),
                .WR_WAIT(3), .TIMEOUT(50)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pattern_sel(pattern_sel), .seed(seed),
    .i2c_rh_wl(b_rh_wl), .i2c_exec(b_exec), .i2c_addr(b_addr), .i2c_data_w(b_data_w),
    .i2c_data_r(b_rdata), .i2c_done(b_done_in), .busy(b_busy), .done(b_done),
    .pass(b_pass), .err_cnt(b_err), .fail_addr(b_fail));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [1:0] p, input logic [7:0] s,
                                     input logic [7:0] a);
    case (p)
      2'd0:    return a;
      2'd1:    return ~a;
      2'd2:    return a ^ s;
      default: return s;
    endcase
  endfunction

  // EEPROM model A: done two cycles after exec; optional dropped done on
  // the third write and optional corruption of the byte at 0x10.
  logic [7:0] a_mem [256];
  logic a_d1 = 1'b0, a_d1_drop = 1'b0;
  int   m_wr = 0;
  always @(posedge clk) begin
    a_d1      <= a_exec;
    a_done_in <= a_d1 & ~a_d1_drop;
    a_d1_drop <= 1'b0;
    if (mon_clr) m_wr <= 0;
    if (a_exec) begin
      if (!a_rh_wl) begin
        a_mem[a_addr[7:0]] <= a_data_w;
        a_d1_drop <= drop_mode && (m_wr == 2);
        m_wr <= m_wr + 1;
      end else begin
        a_rdata <= a_mem[a_addr[7:0]] ^
                   ((corrupt_mode && a_addr[7:0] == 8'h10) ? 8'h01 : 8'h00);
      end
    end
  end

  // EEPROM model B: ideal.
  logic [7:0] b_mem [256];
  logic b_d1 = 1'b0;
  always @(posedge clk) begin
    b_d1      <= b_exec;
    b_done_in <= b_d1;
    if (b_exec) begin
      if (!b_rh_wl) b_mem[b_addr[7:0]] <= b_data_w;
      else          b_rdata <= b_mem[b_addr[7:0]];
    end
  end

  // Bus monitor for instance A.
  int n_wr, n_rd, n_done, hi, cyc;
  int wd_cyc, r_cyc, drop_cyc;
  bit have_wd, have_r;
  logic [15:0] exp_wa, exp_ra;
  initial begin
    n_wr = 0; n_rd = 0; n_done = 0; hi = 0; cyc = 0;
    wd_cyc = 0; r_cyc = 0; drop_cyc = 0; have_wd = 0; have_r = 0;
    exp_wa = 0; exp_ra = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_clr) begin
        n_wr = 0; n_rd = 0; n_done = 0; hi = 0;
        have_wd = 0; have_r = 0; exp_wa = 0; exp_ra = 0;
      end else begin
        if (a_done) n_done++;
        if (a_done_in && !a_rh_wl) begin
          wd_cyc = cyc; have_wd = 1;
        end
        if (a_exec) begin
          hi++;
          if (have_wd) begin
            chk("wdone_to_exec", cyc - wd_cyc - 1, GAP_A + WRW_A);
            have_wd = 0;
          end
          if (!a_rh_wl) begin
            chk("w_addr", a_addr, exp_wa);
            chk("w_data", a_data_w, pat(cur_pat, cur_seed, a_addr[7:0]));
            if (drop_mode && n_wr == 3) chk("timeout_span", cyc - drop_cyc, 1 + TO_A + WRW_A + GAP_A);
            if (n_wr == 2) drop_cyc = cyc;
            exp_wa++; n_wr++;
          end else begin
            chk("r_addr", a_addr, exp_ra);
            if (have_r) chk("r_exec_gap", cyc - r_cyc - 1, GAP_A + LAT);
            r_cyc = cyc; have_r = 1; exp_ra++; n_rd++;
          end
        end else if (hi != 0) begin
          chk("exec_width", hi, 1);
          hi = 0;
        end
      end
    end
  end

  // Address/direction log for instance B.
  logic [15:0] b_log [8];
  logic        b_rw  [8];
  int b_n;
  initial begin
    b_n = 0;
    forever begin
      @(negedge clk);
      if (mon_clr) b_n = 0;
      else if (b_exec) begin
        if (b_n < 8) begin
          b_log[b_n] = b_addr; b_rw[b_n] = b_rh_wl;
        end
        b_n++;
      end
    end
  end

  task automatic run_a(input logic [1:0] p, input logic [7:0] s, input int poke_at);
    bit got;
    got = 0;
    cur_pat = p; cur_seed = s;
    @(posedge clk); #1;
    pattern_sel = p; seed = s; a_start = 1; mon_clr = 1;
    @(posedge clk); #1;
    a_start = 0; mon_clr = 0;
    pattern_sel = ~p; seed = ~s;   // run must use the latched values
    chk("busy_after_start", a_busy, 1);
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (a_done) got = 1;
      a_start = (i == poke_at);
    end
    a_start = 0;
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("done_one_cycle", a_done, 0);
    chk("busy_end", a_busy, 0);
  endtask

  logic [15:0] b_exp [8];

  initial begin
    bit got;
    rst_n = 0; a_start = 0; b_start = 0; pattern_sel = 0; seed = 0;
    mon_clr = 0; drop_mode = 0; corrupt_mode = 0; cur_pat = 0; cur_seed = 0;
    b_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
              16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_exec", a_exec, 0);
    chk("rst_rh_wl", a_rh_wl, 0);
    chk("rst_addr", a_addr, 16'h0000);
    chk("rst_data_w", a_data_w, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);
    chk("rst_err", a_err, 0);
    chk("rst_fail", a_fail, 0);
    chk("rst_b_addr", b_addr, 16'hFFFE);
    @(negedge clk); rst_n = 1;

    // Ideal run, pattern 0, with a start poke while busy.
    run_a(2'd0, 8'h00, 500);
    chk("r1_pass", a_pass, 1);
    chk("r1_err", a_err, 0);
    chk("r1_fail", a_fail, 0);
    chk("r1_nwr", n_wr, 256);
    chk("r1_nrd", n_rd, 256);
    chk("r1_ndone", n_done, 1);

    // Pattern 2, seed A5, corrupted byte at 0x10.
    corrupt_mode = 1;
    run_a(2'd2, 8'hA5, -1);
    corrupt_mode = 0;
    chk("r2_err", a_err, 1);
    chk("r2_fail", a_fail, 16'h0010);
    chk("r2_pass", a_pass, 0);
    chk("r2_nrd", n_rd, 256);

    // Pattern 1, third write never completes.
    drop_mode = 1;
    run_a(2'd1, 8'h00, -1);
    drop_mode = 0;
    chk("r3_err", a_err, 1);
    chk("r3_fail", a_fail, 16'h0002);
    chk("r3_pass", a_pass, 0);
    chk("r3_nwr", n_wr, 256);
    chk("r3_nrd", n_rd, 256);

    // Reset during the read phase, then a full rerun.
    cur_pat = 2'd3; cur_seed = 8'h3C;
    @(posedge clk); #1;
    pattern_sel = 2'd3; seed = 8'h3C; a_start = 1; mon_clr = 1;
    @(posedge clk); #1;
    a_start = 0; mon_clr = 0;
    got = 0;
    for (int i = 0; i < 10000 && !got; i++) begin
      @(negedge clk);
      if (a_rh_wl) got = 1;
    end
    chk("abort_reached_read", got, 1);
    repeat (40) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort_busy", a_busy, 0);
    chk("abort_rh_wl", a_rh_wl, 0);
    chk("abort_addr", a_addr, 16'h0000);
    chk("abort_exec", a_exec, 0);
    chk("abort_data_w", a_data_w, 0);
    chk("abort_err", a_err, 0);
    chk("abort_done", a_done, 0);
    chk("abort_pass", a_pass, 0);
    chk("abort_ndone", n_done, 0);
    @(negedge clk); rst_n = 1;
    run_a(2'd3, 8'h3C, -1);
    chk("r4_pass", a_pass, 1);
    chk("r4_err", a_err, 0);
    chk("r4_nwr", n_wr, 256);
    chk("r4_nrd", n_rd, 256);

    // Instance B: address wrap at the top of the space.
    @(posedge clk); #1;
    pattern_sel = 2'd0; seed = 8'h00; b_start = 1; mon_clr = 1;
    @(posedge clk); #1;
    b_start = 0; mon_clr = 0;
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (b_done) got = 1;
    end
    chk("b_done_seen", got, 1);
    @(negedge clk);
    chk("b_pass", b_pass, 1);
    chk("b_err", b_err, 0);
    chk("b_nexec", b_n, 8);
    for (int k = 0; k < 8; k++) begin
      chk("b_addr", b_log[k], b_exp[k]);
      chk("b_rh_wl", b_rw[k], (k >= 4) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
